psg_bus_sched: RTL
==================

PSG_BUS_SCHED -- requirements
Module: psg_bus_sched

Interface
REQ-001 SHALL have parameter PHASE_LEN, default 1, number of CLK cycles each bus phase (ADDR, DATA, READ) is held; legal range 1..15.
REQ-002 SHALL have parameter ADDR_CACHE, default 1, when 1 the ADDR phase is skipped if the target address equals the last address latched into the PSG.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1  transaction request from requester 0 / 1; held high until ack.
REQ-006 we0 / we1  input  1  1 = register write, 0 = register read.
REQ-007 addr0 / addr1  input  4  PSG register index 0..15.
REQ-008 wdata0 / wdata1  input  8  write data.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-010 rdata  output  8  read result, valid in the ack cycle and held until the next read completes.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 psg_bdir  output  1  drives PSG BDIR.
REQ-013 psg_bc  output  1  drives PSG BC.
REQ-014 psg_di  output  8  drives PSG data-in.
REQ-015 psg_do  input  8  PSG data-out.

Function
REQ-016 FSM states SHALL be IDLE, ADDR, DATA, READ, GAP.
REQ-017 In IDLE with any req high, SHALL grant one requester, latch its we/addr/wdata, and next go to ADDR; if ADDR_CACHE=1, cache valid and latched addr equals cached addr, go directly to DATA (write) or READ (read).
REQ-018 Arbitration: with a single req high, that requester is granted; with both high, the requester not granted last is granted (round robin); the first grant after reset with both high goes to requester 0.
REQ-019 ADDR SHALL drive bdir=1, bc=1, psg_di={4'b0000,addr} for PHASE_LEN cycles, then go to DATA (we=1) or READ (we=0); cache SHALL load addr and become valid on ADDR exit.
REQ-020 DATA SHALL drive bdir=1, bc=0, psg_di=wdata for PHASE_LEN cycles, then go to GAP.
REQ-021 READ SHALL drive bdir=0, bc=1, psg_di=0 for PHASE_LEN cycles, capture psg_do into rdata on the last READ cycle, then go to GAP.
REQ-022 GAP SHALL last exactly one cycle with bdir=0, bc=0, psg_di=0, pulse ack of the granted requester only, and return to IDLE.
REQ-023 IDLE SHALL drive bdir=0, bc=0, psg_di=0; bus outputs SHALL be registered.
REQ-024 Latency, req sampled high in IDLE at cycle 0: with ADDR phase, ack at cycle 2*PHASE_LEN+1; with ADDR skipped, ack at cycle PHASE_LEN+1.
REQ-025 A requester whose req is still high after its ack SHALL be treated as a new request in the following IDLE cycle, subject to round robin.
REQ-026 Deassertion of req or changes of we/addr/wdata after grant SHALL NOT alter the transaction in progress; it completes and ack still pulses.
REQ-027 Phase counter SHALL be 4 bits, load PHASE_LEN-1 on phase entry, decrement each cycle, exit phase at zero.
REQ-028 Never SHALL both ack0 and ack1 be high in the same cycle, and never SHALL bdir=1 with bc=1 outside ADDR.

Reset
REQ-029 RESET SHALL force IDLE, bdir=0, bc=0, psg_di=0, ack0=ack1=0, rdata=0, busy=0, cache invalid, last-grant = requester 1 (so requester 0 wins first tie), phase counter 0.
REQ-030 RESET asserted mid-transaction SHALL abort it with no ack and leave cache invalid.

Verification (PHASE_LEN=2, ADDR_CACHE=1)
REQ-031 After reset, req0 write addr=7 wdata=0x38 -> cycles 1-2 bdir/bc=11 psg_di=0x07, cycles 3-4 bdir/bc=10 psg_di=0x38, ack0 at cycle 5.
REQ-032 Then req0 write addr=7 wdata=0x3F -> ADDR skipped, cycles 1-2 bdir/bc=10 psg_di=0x3F, ack0 at cycle 3.
REQ-033 req1 read addr=14 with psg_do=0xA5 -> ADDR phase psg_di=0x0E, READ cycles bdir/bc=01, ack1 at cycle 5 with rdata=0xA5.
REQ-034 req0 and req1 raised together and held, both writes -> grants alternate 0,1,0,1; acks never coincide.
REQ-035 RESET pulsed during DATA -> bus 00 next cycle, no ack, following same-address write performs full ADDR phase.

Source files
------------

// File: rtl/psg_bus_sched.sv
// psg_bus_sched: round-robin scheduler for two requesters sharing a PSG register bus.
// Sequences ADDR/DATA/READ/GAP phases and skips ADDR when the PSG already holds the address.
module psg_bus_sched #(
  parameter int PHASE_LEN  = 1,
  parameter bit ADDR_CACHE = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       psg_bdir,
  output logic       psg_bc,
  output logic [7:0] psg_di,
  input  logic [7:0] psg_do
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, READ, GAP} state_t;
  localparam logic [3:0] PL1 = 4'(PHASE_LEN - 1);
  state_t state;
  logic [3:0] cnt, cur_addr, cache_addr, sel_addr;
  logic [7:0] cur_wdata, sel_wdata;
  logic cur_we, gnt, last_gnt, cache_v, sel, sel_we, hit;
  // last_gnt=1 means requester 1 won most recently, so a tie goes to requester 0
  always_comb begin
    sel = req1 & (~req0 | ~last_gnt);
    sel_we = sel ? we1 : we0;
    sel_addr = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    hit = ADDR_CACHE & cache_v & (cache_addr == sel_addr);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      {psg_bdir, psg_bc} <= 2'b00;
      psg_di <= 8'h00;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata <= 8'h00;
      busy <= 1'b0;
      cache_v <= 1'b0;
      cache_addr <= 4'h0;
      last_gnt <= 1'b1;
      cnt <= 4'h0;
      gnt <= 1'b0;
      cur_we <= 1'b0;
      cur_addr <= 4'h0;
      cur_wdata <= 8'h00;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          gnt <= sel;
          last_gnt <= sel;
          cur_we <= sel_we;
          cur_addr <= sel_addr;
          cur_wdata <= sel_wdata;
          cnt <= PL1;
          busy <= 1'b1;
          state <= hit ? (sel_we ? DATA : READ) : ADDR;
          {psg_bdir, psg_bc} <= hit ? {sel_we, ~sel_we} : 2'b11;
          psg_di <= hit ? (sel_we ? sel_wdata : 8'h00) : {4'b0000, sel_addr};
        end
        ADDR: if (cnt != 4'h0) cnt <= cnt - 1'b1;
        else begin
          cnt <= PL1;
          cache_v <= 1'b1;
          cache_addr <= cur_addr;
          state <= cur_we ? DATA : READ;
          {psg_bdir, psg_bc} <= {cur_we, ~cur_we};
          psg_di <= cur_we ? cur_wdata : 8'h00;
        end
        DATA, READ: if (cnt != 4'h0) cnt <= cnt - 1'b1;
        else begin
          if (state == READ) rdata <= psg_do;
          state <= GAP;
          {psg_bdir, psg_bc} <= 2'b00;
          psg_di <= 8'h00;
          ack0 <= ~gnt;
          ack1 <= gnt;
        end
        GAP: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
